exmem_stage: RTL and testbench
==============================

EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of ALU result, store data and branch target.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, width of destination register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  EX stage presents a valid instruction result.
REQ-006 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port ALUResult  input  DATA_WIDTH  result from the ALU.
REQ-008 SHALL have port StoreData  input  DATA_WIDTH  rs2 value for stores.
REQ-009 SHALL have ports Rd (input, REG_ADDR_WIDTH) and RegWrite, MemRead, MemWrite, Branch (input, 1 each): EX control fields.
REQ-010 SHALL have port PcBranch  input  DATA_WIDTH  branch target computed in EX.
REQ-011 SHALL have port flush  input  1  discard all held and incoming entries.
REQ-012 SHALL have port out_valid  output  1  head entry valid toward MEM.
REQ-013 SHALL have port out_ready  input  1  MEM consumes head entry this cycle.
REQ-014 SHALL have outputs out_ALUResult, out_StoreData, out_PcBranch (DATA_WIDTH), out_Rd (REG_ADDR_WIDTH), and out_RegWrite, out_MemRead, out_MemWrite, out_BranchTaken (1 each): head entry fields.

Function
REQ-015 SHALL accept an entry on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-016 SHALL pop the head entry on a rising edge where out_valid=1, out_ready=1 and flush=0.
REQ-017 SHALL compute the stored BranchTaken field as Branch & ALUResult[0] at acceptance; all other fields are stored unmodified.
REQ-018 SHALL present the head entry on out_* with one-cycle latency from acceptance into an empty stage.
REQ-019 SHALL drive all out_* data and control fields to zero whenever out_valid=0.
REQ-020 SHALL preserve entry order (FIFO); held outputs stay stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on flush=1, empty the stage on that edge, drop any same-cycle input and suppress any same-cycle pop; flush takes priority over push and pop.
REQ-022 SHALL never overwrite an unconsumed entry; a push when full is impossible because in_ready=0.

Reset
REQ-023 SHALL, on reset=1 at a rising edge, empty the stage: out_valid=0, all out_* fields 0, occupancy 0; reset overrides flush, push and pop.
REQ-024 SHALL drive in_ready=1 in the first cycle after reset is released.

Configuration
REQ-025 SHALL, when EXMEM_SKID_EN is defined, implement two entries with in_ready = (occupancy < 2) derived only from registers (no combinational path from out_ready to in_ready); simultaneous push and pop at occupancy 1 keeps occupancy 1.
REQ-026 SHALL, when EXMEM_SKID_EN is not defined, implement one entry with in_ready = !out_valid | out_ready (combinational); push and pop in the same cycle when full replaces the entry.

Verification
REQ-027 SHALL cover: reset, then ALUResult=0x0000_0010, Rd=5, RegWrite=1, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_ALUResult=0x10, out_Rd=5, out_RegWrite=1.
REQ-028 SHALL cover: Branch=1 with ALUResult=1, PcBranch=0x40 -> out_BranchTaken=1, out_PcBranch=0x40; Branch=1 with ALUResult=0 -> out_BranchTaken=0.
REQ-029 SHALL cover: out_ready=0, three back-to-back pushes 0xA,0xB,0xC -> with EXMEM_SKID_EN, 0xA,0xB held and in_ready=0; without it, only 0xA held; releasing out_ready drains in push order.
REQ-030 SHALL cover: stage holding two entries, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, all out_* zero, no entry consumed or accepted.
REQ-031 SHALL cover: reset=1 asserted mid-stream while out_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1, outputs zero.
REQ-032 SHALL cover: continuous in_valid=1, out_ready=1 over 8 cycles with data 1..8 -> out_ALUResult shows 1..8 on consecutive cycles, no bubbles after the first.

Source files
------------

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush and synchronous reset.
// Define EXMEM_SKID_EN for a two-entry skid buffer with a registered in_ready; the default build holds one entry.
module exmem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic [DATA_WIDTH-1:0]     StoreData,
    input  logic [REG_ADDR_WIDTH-1:0] Rd,
    input  logic                      RegWrite,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      Branch,
    input  logic [DATA_WIDTH-1:0]     PcBranch,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_ALUResult,
    output logic [DATA_WIDTH-1:0]     out_StoreData,
    output logic [DATA_WIDTH-1:0]     out_PcBranch,
    output logic [REG_ADDR_WIDTH-1:0] out_Rd,
    output logic                      out_RegWrite,
    output logic                      out_MemRead,
    output logic                      out_MemWrite,
    output logic                      out_BranchTaken
);

    localparam int ENTRY_W = 3 * DATA_WIDTH + REG_ADDR_WIDTH + 4;

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;
    logic               branch_taken;

    // The branch decision is resolved once, when the entry is captured.
    assign branch_taken = Branch & ALUResult[0];
    assign in_entry     = {ALUResult, StoreData, PcBranch, Rd,
                           RegWrite, MemRead, MemWrite, branch_taken};

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

`ifdef EXMEM_SKID_EN
    logic [ENTRY_W-1:0] slot1;
    logic [1:0]         count;

    // head is the oldest entry; slot1 only ever holds the second-oldest.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= 2'd0;
            head  <= '0;
            slot1 <= '0;
        end else begin
            if (pop) begin
                if (count == 2'd2) begin
                    head <= slot1;
                end else if (push) begin
                    head <= in_entry;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head <= in_entry;
                end else begin
                    slot1 <= in_entry;
                end
            end

            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
`else
    logic full;

    // A push while full is only possible when the head is popped in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            full <= 1'b0;
            head <= '0;
        end else if (push) begin
            full <= 1'b1;
            head <= in_entry;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    assign in_ready  = ~full | out_ready;
    assign out_valid = full;
`endif

    assign {out_ALUResult, out_StoreData, out_PcBranch, out_Rd,
            out_RegWrite, out_MemRead, out_MemWrite, out_BranchTaken} = out_valid ? head : '0;

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard testbench for exmem_stage; expectations follow EXMEM_SKID_EN when it is defined.
module tb_exmem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        bt;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ALUResult = '0;
    logic [31:0] StoreData = '0;
    logic [4:0]  Rd = '0;
    logic        RegWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        Branch = 1'b0;
    logic [31:0] PcBranch = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_ALUResult;
    logic [31:0] out_StoreData;
    logic [31:0] out_PcBranch;
    logic [4:0]  out_Rd;
    logic        out_RegWrite;
    logic        out_MemRead;
    logic        out_MemWrite;
    logic        out_BranchTaken;

    logic [$bits(entry_t):0] act_out;
    entry_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    exmem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUResult(ALUResult), .StoreData(StoreData), .Rd(Rd),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .PcBranch(PcBranch), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_ALUResult(out_ALUResult), .out_StoreData(out_StoreData), .out_PcBranch(out_PcBranch),
        .out_Rd(out_Rd), .out_RegWrite(out_RegWrite), .out_MemRead(out_MemRead),
        .out_MemWrite(out_MemWrite), .out_BranchTaken(out_BranchTaken)
    );

    always #5 clk = ~clk;

    assign act_out = {out_valid, out_ALUResult, out_StoreData, out_PcBranch, out_Rd,
                      out_RegWrite, out_MemRead, out_MemWrite, out_BranchTaken};

    function automatic logic [$bits(entry_t):0] exp_out();
        if (sb.size() == 0) return '0;
        return {1'b1, sb[0]};
    endfunction

    function automatic logic exp_in_ready();
`ifdef EXMEM_SKID_EN
        return sb.size() < 2;
`else
        return (sb.size() == 0) || out_ready;
`endif
    endfunction

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic br);
        in_valid = v; ALUResult = alu; StoreData = sd; PcBranch = pc; Rd = rd;
        RegWrite = rw; MemRead = mr; MemWrite = mw; Branch = br;
    endtask

    // Advance one clock and apply the same handshake to the scoreboard.
    task automatic tick();
        logic   do_push;
        logic   do_pop;
        entry_t e;
        #1;
        do_push = in_valid && exp_in_ready() && !flush;
        do_pop  = (sb.size() != 0) && out_ready && !flush;
        e = '{alu: ALUResult, sd: StoreData, pc: PcBranch, rd: Rd, rw: RegWrite,
              mr: MemRead, mw: MemWrite, bt: Branch & ALUResult[0]};
        @(posedge clk);
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (act_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", act_out);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b1, 32'h10, '0, '0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (act_out !== exp_out()) begin
            n_fail++;
            $display("[TB] FAIL basic_head: got %h expected %h", act_out, exp_out());
        end
        n_checks++;
        if ({out_valid, out_ALUResult, out_Rd, out_RegWrite} !== {1'b1, 32'h10, 5'd5, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL basic_fields: got v=%b alu=%h rd=%0d rw=%b expected v=1 alu=10 rd=5 rw=1",
                     out_valid, out_ALUResult, out_Rd, out_RegWrite);
        end
        tick();
        #1;
        n_checks++;
        if (act_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL basic_drain: got %h expected 0", act_out);
        end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        drive(1'b1, 32'h1, 32'h5, 32'h40, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h0, 32'h6, 32'h80, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if ({out_BranchTaken, out_PcBranch} !== {1'b1, 32'h40}) begin
            n_fail++;
            $display("[TB] FAIL branch_taken: got bt=%b pc=%h expected bt=1 pc=40", out_BranchTaken, out_PcBranch);
        end
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({out_valid, out_BranchTaken, out_PcBranch} !== {1'b1, 1'b0, 32'h80}) begin
            n_fail++;
            $display("[TB] FAIL branch_not_taken: got v=%b bt=%b pc=%h expected v=1 bt=0 pc=80",
                     out_valid, out_BranchTaken, out_PcBranch);
        end
        n_checks++;
        if (act_out !== exp_out()) begin
            n_fail++;
            $display("[TB] FAIL branch_head: got %h expected %h", act_out, exp_out());
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA + i, 32'h100 + i, '0, 5'(i + 1), 1'b1, 1'b0, 1'b1, 1'b0);
            #1;
            n_checks++;
            if (in_ready !== exp_in_ready()) begin
                n_fail++;
                $display("[TB] FAIL bp_in_ready push %0d: got %b expected %b", i, in_ready, exp_in_ready());
            end
            tick();
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({out_valid, out_ALUResult, in_ready} !== {1'b1, 32'hA, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL bp_hold: got v=%b alu=%h in_ready=%b expected v=1 alu=a in_ready=0",
                     out_valid, out_ALUResult, in_ready);
        end
        tick();
        #1;
        n_checks++;
        if (act_out !== exp_out()) begin
            n_fail++;
            $display("[TB] FAIL bp_stable: got %h expected %h", act_out, exp_out());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (act_out !== exp_out()) begin
                n_fail++;
                $display("[TB] FAIL bp_drain %0d: got %h expected %h", i, act_out, exp_out());
            end
            tick();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h21, '0, '0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, '0, '0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h23, '0, '0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (act_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL flush_empty: got %h expected 0", act_out);
        end
        tick();
        #1;
        n_checks++;
        if ({act_out, in_ready} !== {{($bits(entry_t) + 1){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL flush_no_accept: got %h in_ready=%b expected 0 in_ready=1", act_out, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h31, 32'h7, 32'h8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rmid_pre_valid: got %b expected 1", out_valid);
        end
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h32, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({act_out, in_ready} !== {{($bits(entry_t) + 1){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL rmid_state: got %h in_ready=%b expected 0 in_ready=1", act_out, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 32'(i * 3), 32'(i * 4), 5'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            #1;
            n_checks++;
            if ({out_valid, out_ALUResult} !== {1'b1, 32'(i)}) begin
                n_fail++;
                $display("[TB] FAIL b2b cycle %0d: got v=%b alu=%h expected v=1 alu=%h", i, out_valid, out_ALUResult, 32'(i));
            end
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        n_checks++;
        if (act_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL b2b_drain: got %h expected 0", act_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++;
            if ({act_out, in_ready} !== {exp_out(), exp_in_ready()}) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got %h rdy=%b expected %h rdy=%b",
                         i, act_out, in_ready, exp_out(), exp_in_ready());
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
